// File: rtl/bus_mem_pkg.sv
// Shared definitions for bus_mem: I/O page layout, register offsets,
// CTRL/STATUS bit positions and the address decoder.
package bus_mem_pkg;

    localparam logic [15:0] IO_BASE = 16'hFF00;

    localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h01;
    localparam logic [7:0] OFF_TMR_LO   = 8'h02;
    localparam logic [7:0] OFF_TMR_HI   = 8'h03;
    localparam logic [7:0] OFF_CMP_LO   = 8'h04;
    localparam logic [7:0] OFF_CMP_HI   = 8'h05;
    localparam logic [7:0] OFF_CTRL     = 8'h06;
    localparam logic [7:0] OFF_STATUS   = 8'h07;
    localparam logic [7:0] OFF_PRE      = 8'h08;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_AUTOCLR = 2;
    localparam int STATUS_MATCH = 0;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_GPIO_OUT,
        SEL_GPIO_IN,
        SEL_TMR_LO,
        SEL_TMR_HI,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_CTRL,
        SEL_STATUS,
        SEL_PRE
    } reg_sel_e;

    // RAM occupies the bottom 2^ram_aw bytes; only the 0xFF00 page holds registers.
    function automatic reg_sel_e decode_addr(input logic [15:0] addr, input int ram_aw);
        reg_sel_e sel;
        sel = SEL_NONE;
        if ((addr >> ram_aw) == 16'h0000) begin
            sel = SEL_RAM;
        end else if (addr[15:8] == IO_BASE[15:8]) begin
            case (addr[7:0])
                OFF_GPIO_OUT: sel = SEL_GPIO_OUT;
                OFF_GPIO_IN:  sel = SEL_GPIO_IN;
                OFF_TMR_LO:   sel = SEL_TMR_LO;
                OFF_TMR_HI:   sel = SEL_TMR_HI;
                OFF_CMP_LO:   sel = SEL_CMP_LO;
                OFF_CMP_HI:   sel = SEL_CMP_HI;
                OFF_CTRL:     sel = SEL_CTRL;
                OFF_STATUS:   sel = SEL_STATUS;
                OFF_PRE:      sel = SEL_PRE;
                default:      sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_mem_if.sv
// CPU-side bus of bus_mem: one transfer per clock, read=1 reads, read=0 writes.
interface bus_mem_if;

    logic        read;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    modport master (output read, output address, output wdata, input rdata);
    modport slave  (input read, input address, input wdata, output rdata);

endinterface

// File: rtl/bus_mem_timer.sv
// Prescaled 16-bit timer with compare/match, auto-clear and an atomic
// 16-bit read through a high-byte shadow latched on TMR_LO reads.
module bus_mem_timer
    import bus_mem_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_sel_e sel,
    input  logic     wr,
    input  logic     rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic     irq
);

    logic [2:0]  ctrl;
    logic        match;
    logic [7:0]  pre;
    logic [7:0]  presc;
    logic [15:0] counter;
    logic [15:0] cmp;
    logic [7:0]  shadow;
    logic        tick;
    logic        hit;

    assign tick = ctrl[CTRL_EN] && (presc == 8'h00);
    assign hit  = (counter == cmp);
    assign irq  = match & ctrl[CTRL_IRQ_EN];

    // Software writes beat the tick on the counter; a match beats the W1C on STATUS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl    <= 3'b000;
            match   <= 1'b0;
            pre     <= 8'h00;
            presc   <= 8'h00;
            counter <= 16'h0000;
            cmp     <= 16'h0000;
            shadow  <= 8'h00;
        end else begin
            if (wr && sel == SEL_PRE) begin
                pre   <= wdata;
                presc <= wdata;
            end else if (ctrl[CTRL_EN]) begin
                presc <= (presc == 8'h00) ? pre : presc - 8'h01;
            end

            if (wr && sel == SEL_CTRL)   ctrl       <= wdata[2:0];
            if (wr && sel == SEL_CMP_LO) cmp[7:0]   <= wdata;
            if (wr && sel == SEL_CMP_HI) cmp[15:8]  <= wdata;

            if (wr && sel == SEL_TMR_LO) begin
                counter[7:0] <= wdata;
            end else if (wr && sel == SEL_TMR_HI) begin
                counter[15:8] <= wdata;
            end else if (tick) begin
                counter <= (hit && ctrl[CTRL_AUTOCLR]) ? 16'h0000 : counter + 16'h0001;
            end

            if (tick && hit) begin
                match <= 1'b1;
            end else if (wr && sel == SEL_STATUS && wdata[STATUS_MATCH]) begin
                match <= 1'b0;
            end

            if (rd && sel == SEL_TMR_LO) shadow <= counter[15:8];
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (sel)
            SEL_TMR_LO: rdata = counter[7:0];
            SEL_TMR_HI: rdata = shadow;
            SEL_CMP_LO: rdata = cmp[7:0];
            SEL_CMP_HI: rdata = cmp[15:8];
            SEL_CTRL:   rdata = {5'b00000, ctrl};
            SEL_STATUS: rdata = {7'b0000000, match};
            SEL_PRE:    rdata = pre;
            default:    rdata = 8'h00;
        endcase
    end

endmodule

// File: rtl/bus_mem.sv
// Byte-wide RAM plus GPIO and optional timer on the 0xFF00 I/O page.
// The timer is built only when BUS_MEM_TIMER_EN is defined.
module bus_mem
    import bus_mem_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic       clk,
    input  logic       rst,
    bus_mem_if.slave   bus,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       irq
);

    reg_sel_e          sel;
    logic              wr;
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]        mem [2**RAM_AW];
    logic [7:0]        gpio_sync1;
    logic [7:0]        gpio_sync2;
    logic [7:0]        tmr_rdata;
    logic [7:0]        rd_mux;

    assign sel     = decode_addr(bus.address, RAM_AW);
    assign wr      = ~bus.read;
    assign ram_idx = bus.address[RAM_AW-1:0];

    // RAM has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr && sel == SEL_RAM) mem[ram_idx] <= bus.wdata;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (sel)
            SEL_NONE:     rd_mux = 8'h00;
            SEL_RAM:      rd_mux = mem[ram_idx];
            SEL_GPIO_OUT: rd_mux = gpio_out;
            SEL_GPIO_IN:  rd_mux = gpio_sync2;
            default:      rd_mux = tmr_rdata;
        endcase
    end

    // rdata samples the old location value, so a write cycle returns pre-write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata  <= 8'h00;
            gpio_out   <= 8'h00;
            gpio_sync1 <= 8'h00;
            gpio_sync2 <= 8'h00;
        end else begin
            bus.rdata  <= rd_mux;
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            if (wr && sel == SEL_GPIO_OUT) gpio_out <= bus.wdata;
        end
    end

`ifdef BUS_MEM_TIMER_EN
    bus_mem_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .wr    (wr),
        .rd    (bus.read),
        .wdata (bus.wdata),
        .rdata (tmr_rdata),
        .irq   (irq)
    );
`else
    assign tmr_rdata = 8'h00;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mem.sv
// Directed bench for bus_mem: RAM, GPIO, timer (or its absence) and async reset.
// Timer steps follow the same BUS_MEM_TIMER_EN macro as the design.
module tb_bus_mem;

    logic       clk;
    logic       rst;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       irq;
    int         errors;
    int         checks;

    bus_mem_if bus();

    bus_mem #(.RAM_AW(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // One bus transfer: drive after a falling edge, return at the next falling edge.
    task automatic apply_stimulus(input logic rd, input logic [15:0] addr, input logic [7:0] wd);
        bus.read    = rd;
        bus.address = addr;
        bus.wdata   = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        gpio_in     = 8'h00;
        bus.read    = 1'b1;
        bus.address = 16'h0000;
        bus.wdata   = 8'h00;

        #12;
        check_output("reset_rdata", bus.rdata, 8'h00);
        check_output("reset_gpio_out", gpio_out, 8'h00);
        check_output("reset_irq", {7'b0, irq}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // RAM, including the top byte and the first address past it
        apply_stimulus(1'b0, 16'h0123, 8'hA5);
        apply_stimulus(1'b1, 16'h0123, 8'h00);
        check_output("ram_read_0123", bus.rdata, 8'hA5);
        apply_stimulus(1'b1, 16'h8000, 8'h00);
        check_output("unmapped_8000", bus.rdata, 8'h00);
        apply_stimulus(1'b0, 16'h0000, 8'h11);
        apply_stimulus(1'b0, 16'h03FF, 8'h5A);
        apply_stimulus(1'b0, 16'h0400, 8'h77);
        apply_stimulus(1'b1, 16'h0400, 8'h00);
        check_output("past_ram_0400", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'h0000, 8'h00);
        check_output("ram_no_alias_0000", bus.rdata, 8'h11);
        apply_stimulus(1'b1, 16'h03FF, 8'h00);
        check_output("ram_top_03ff", bus.rdata, 8'h5A);
        apply_stimulus(1'b0, 16'h0123, 8'h3E);
        check_output("read_before_write", bus.rdata, 8'hA5);
        apply_stimulus(1'b1, 16'h0123, 8'h00);
        check_output("ram_rewrite_0123", bus.rdata, 8'h3E);

        // GPIO
        apply_stimulus(1'b0, 16'hFF00, 8'h3C);
        check_output("gpio_out_pin", gpio_out, 8'h3C);
        apply_stimulus(1'b1, 16'hFF00, 8'h00);
        check_output("gpio_out_read", bus.rdata, 8'h3C);
        gpio_in = 8'h81;
        apply_stimulus(1'b1, 16'hFF01, 8'h00);
        check_output("gpio_in_edge1", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'hFF01, 8'h00);
        check_output("gpio_in_edge2", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'hFF01, 8'h00);
        check_output("gpio_in_edge3", bus.rdata, 8'h81);
        apply_stimulus(1'b0, 16'hFF01, 8'h00);
        apply_stimulus(1'b1, 16'hFF01, 8'h00);
        check_output("gpio_in_readonly", bus.rdata, 8'h81);
        apply_stimulus(1'b0, 16'hFF09, 8'h55);
        apply_stimulus(1'b1, 16'hFF09, 8'h00);
        check_output("unmapped_ff09", bus.rdata, 8'h00);

`ifdef BUS_MEM_TIMER_EN
        // PRE=1 gives a tick every 2nd clock; the 5th tick hits CMP=4 at clock 10
        apply_stimulus(1'b0, 16'hFF08, 8'h01);
        apply_stimulus(1'b0, 16'hFF04, 8'h04);
        apply_stimulus(1'b0, 16'hFF05, 8'h00);
        apply_stimulus(1'b0, 16'hFF06, 8'h07);
        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 16'hFF07, 8'h00);
        check_output("irq_before_match", {7'b0, irq}, 8'h00);
        apply_stimulus(1'b1, 16'hFF07, 8'h00);
        check_output("irq_at_match", {7'b0, irq}, 8'h01);
        check_output("status_pre_update", bus.rdata, 8'h00);
        apply_stimulus(1'b0, 16'hFF06, 8'h06);
        check_output("ctrl_old_value", bus.rdata, 8'h07);
        apply_stimulus(1'b1, 16'hFF02, 8'h00);
        check_output("autoclr_tmr_lo", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'hFF03, 8'h00);
        check_output("autoclr_tmr_hi", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'hFF07, 8'h00);
        check_output("status_match", bus.rdata, 8'h01);
        apply_stimulus(1'b0, 16'hFF07, 8'h01);
        check_output("status_w1c_old", bus.rdata, 8'h01);
        check_output("irq_after_clear", {7'b0, irq}, 8'h00);
        apply_stimulus(1'b1, 16'hFF07, 8'h00);
        check_output("status_cleared", bus.rdata, 8'h00);

        // Clear-write lands on the same edge as the match tick
        apply_stimulus(1'b0, 16'hFF02, 8'h04);
        apply_stimulus(1'b0, 16'hFF03, 8'h00);
        apply_stimulus(1'b0, 16'hFF08, 8'h00);
        apply_stimulus(1'b0, 16'hFF06, 8'h07);
        apply_stimulus(1'b0, 16'hFF07, 8'h01);
        check_output("collision_irq", {7'b0, irq}, 8'h01);
        apply_stimulus(1'b0, 16'hFF06, 8'h00);
        apply_stimulus(1'b1, 16'hFF07, 8'h00);
        check_output("collision_status", bus.rdata, 8'h01);
        apply_stimulus(1'b1, 16'hFF02, 8'h00);
        check_output("collision_tmr_lo", bus.rdata, 8'h01);
        apply_stimulus(1'b0, 16'hFF07, 8'h01);

        // Wrap 0xFFFF -> 0x0000 and the TMR_HI shadow
        apply_stimulus(1'b0, 16'hFF02, 8'hFF);
        apply_stimulus(1'b0, 16'hFF03, 8'hFF);
        apply_stimulus(1'b0, 16'hFF06, 8'h01);
        apply_stimulus(1'b0, 16'hFF06, 8'h00);
        apply_stimulus(1'b1, 16'hFF02, 8'h00);
        check_output("wrap_tmr_lo", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'hFF03, 8'h00);
        check_output("wrap_tmr_hi", bus.rdata, 8'h00);
        apply_stimulus(1'b0, 16'hFF02, 8'hFF);
        apply_stimulus(1'b0, 16'hFF03, 8'hFF);
        apply_stimulus(1'b0, 16'hFF06, 8'h01);
        apply_stimulus(1'b1, 16'hFF02, 8'h00);
        check_output("shadow_tmr_lo", bus.rdata, 8'hFF);
        apply_stimulus(1'b1, 16'hFF03, 8'h00);
        check_output("shadow_tmr_hi", bus.rdata, 8'hFF);
        apply_stimulus(1'b0, 16'hFF06, 8'h00);
        apply_stimulus(1'b1, 16'hFF02, 8'h00);
        check_output("count_after_wrap", bus.rdata, 8'h02);

        // Run to a match from 2 with CMP=4, then reset mid-count
        apply_stimulus(1'b0, 16'hFF06, 8'h07);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 16'hFF07, 8'h00);
        check_output("irq_before_reset", {7'b0, irq}, 8'h01);
`else
        apply_stimulus(1'b0, 16'hFF06, 8'h07);
        apply_stimulus(1'b0, 16'hFF02, 8'h12);
        apply_stimulus(1'b0, 16'hFF08, 8'h01);
        apply_stimulus(1'b1, 16'hFF02, 8'h00);
        check_output("no_timer_tmr_lo", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'hFF06, 8'h00);
        check_output("no_timer_ctrl", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'hFF08, 8'h00);
        check_output("no_timer_pre", bus.rdata, 8'h00);
        check_output("no_timer_irq", {7'b0, irq}, 8'h00);
`endif

        apply_stimulus(1'b1, 16'h0123, 8'h00);
        check_output("ram_before_reset", bus.rdata, 8'h3E);
        #2 rst = 1'b1;
        #1;
        check_output("async_reset_rdata", bus.rdata, 8'h00);
        check_output("async_reset_gpio_out", gpio_out, 8'h00);
        check_output("async_reset_irq", {7'b0, irq}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
`ifdef BUS_MEM_TIMER_EN
        apply_stimulus(1'b1, 16'hFF06, 8'h00);
        check_output("reset_ctrl", bus.rdata, 8'h00);
        apply_stimulus(1'b1, 16'hFF02, 8'h00);
        check_output("reset_tmr_lo", bus.rdata, 8'h00);
`endif
        apply_stimulus(1'b1, 16'h0123, 8'h00);
        check_output("ram_after_reset", bus.rdata, 8'h3E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
